// File: rtl/audio_sample_sequencer.sv
// Per-sample controller between the codec handshake and the left/right filter pair.
// Optional macro AUDIO_SEQ_COUNT_EN enables the 16-bit completed-write counter on sample_count.

module audio_sample_sequencer #(
  parameter int unsigned DW           = 24,
  parameter int unsigned PROC_TIMEOUT = 1024
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          read_ready,
  input  logic          write_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  output logic          write,
  output logic [DW-1:0] writedata_left,
  output logic [DW-1:0] writedata_right,
  input  logic          bypass,
  output logic [DW-1:0] filt_in_left,
  output logic [DW-1:0] filt_in_right,
  output logic          filt_valid,
  input  logic          filt_done,
  input  logic [DW-1:0] filt_out_left,
  input  logic [DW-1:0] filt_out_right,
  output logic          busy,
  output logic          timeout_flag,
  output logic [15:0]   sample_count
);

  localparam int unsigned CntW = (PROC_TIMEOUT > 2) ? $clog2(PROC_TIMEOUT) : 1;
  localparam logic [CntW-1:0] WdLast = CntW'(PROC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StIssue,
    StWaitf,
    StWrite
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   raw_l_q, raw_l_d, raw_r_q, raw_r_d;
  logic [DW-1:0]   res_l_q, res_l_d, res_r_q, res_r_d;
  logic [DW-1:0]   wdata_l_q, wdata_l_d, wdata_r_q, wdata_r_d;
  logic            mode_q, mode_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    state_d   = state_q;
    raw_l_d   = raw_l_q;
    raw_r_d   = raw_r_q;
    res_l_d   = res_l_q;
    res_r_d   = res_r_q;
    wdata_l_d = wdata_l_q;
    wdata_r_d = wdata_r_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    wd_cnt_d  = wd_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (read_ready && write_ready) state_d = StCapture;
      end
      StCapture: begin
        raw_l_d = readdata_left;
        raw_r_d = readdata_right;
        mode_d  = bypass;
        state_d = bypass ? StWrite : StIssue;
      end
      StIssue: begin
        wd_cnt_d = '0;
        state_d  = StWaitf;
      end
      StWaitf: begin
        // filt_done has priority over a simultaneous watchdog expiry
        if (filt_done) begin
          res_l_d = filt_out_left;
          res_r_d = filt_out_right;
          state_d = StWrite;
        end else if (wd_cnt_q == WdLast) begin
          res_l_d   = raw_l_q;
          res_r_d   = raw_r_q;
          timeout_d = 1'b1;
          state_d   = StWrite;
        end else begin
          wd_cnt_d = wd_cnt_q + CntW'(1);
        end
      end
      StWrite: begin
        if (write_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Output data is frozen on entry to WRITE so it stays stable through backpressure
    if (state_d == StWrite && state_q != StWrite) begin
      wdata_l_d = mode_d ? raw_l_d : res_l_d;
      wdata_r_d = mode_d ? raw_r_d : res_r_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StIdle;
      raw_l_q   <= '0;
      raw_r_q   <= '0;
      res_l_q   <= '0;
      res_r_q   <= '0;
      wdata_l_q <= '0;
      wdata_r_q <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      raw_l_q   <= raw_l_d;
      raw_r_q   <= raw_r_d;
      res_l_q   <= res_l_d;
      res_r_q   <= res_r_d;
      wdata_l_q <= wdata_l_d;
      wdata_r_q <= wdata_r_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign read            = (state_q == StCapture);
  assign filt_valid      = (state_q == StIssue);
  // The push fires in the same cycle the codec reports space while in WRITE
  assign write           = (state_q == StWrite) && write_ready;
  assign busy            = (state_q != StIdle);
  assign filt_in_left    = raw_l_q;
  assign filt_in_right   = raw_r_q;
  assign writedata_left  = wdata_l_q;
  assign writedata_right = wdata_r_q;
  assign timeout_flag    = timeout_q;

`ifdef AUDIO_SEQ_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= '0;
    end else if (write) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign sample_count = count_q;
`else
  assign sample_count = '0;
`endif

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Randomized self-checking bench for audio_sample_sequencer; expected behaviour is derived
// per sample from the cycle-level timing rules (latency, watchdog deadline, backpressure).

module tb_audio_sample_sequencer;

  localparam int T = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset, read_ready, write_ready, bypass, filt_done;
  logic [23:0] readdata_left, readdata_right, filt_out_left, filt_out_right;
  logic        read, write, filt_valid, busy, timeout_flag;
  logic [23:0] writedata_left, writedata_right, filt_in_left, filt_in_right;
  logic [15:0] sample_count;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [23:0] m_wd_l, m_wd_r;
  bit          m_to;
  int unsigned m_cnt;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_sample_sequencer #(
    .DW          (24),
    .PROC_TIMEOUT(T)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .read           (read),
    .write          (write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .bypass         (bypass),
    .filt_in_left   (filt_in_left),
    .filt_in_right  (filt_in_right),
    .filt_valid     (filt_valid),
    .filt_done      (filt_done),
    .filt_out_left  (filt_out_left),
    .filt_out_right (filt_out_right),
    .busy           (busy),
    .timeout_flag   (timeout_flag),
    .sample_count   (sample_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef AUDIO_SEQ_COUNT_EN
    return 16'(m_cnt);
`else
    return 16'd0;
`endif
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      read_ready  = 1'($urandom);
      write_ready = 1'b0;
      bypass      = 1'($urandom);
      filt_done   = 1'($urandom);
      #1;
      check("idle_busy", busy, 0);
      check("idle_read", read, 0);
      check("idle_write", write, 0);
      check("idle_wd_l", writedata_left, m_wd_l);
      check("idle_wd_r", writedata_right, m_wd_r);
      check("idle_to", timeout_flag, m_to);
    end
  endtask

  // One sample: cycle 0 is the IDLE detect cycle. Filter result arrives d cycles after
  // filt_valid; write_ready is held low for s cycles once WRITE is reached.
  task automatic run_sample(input bit bp, input logic [23:0] l, input logic [23:0] r,
                            input int d, input logic [23:0] fl, input logic [23:0] fr,
                            input int s, input bit early);
    bit          filt_ok;
    int          cw, ce;
    logic [23:0] el, er;
    filt_ok = !bp && (d <= T);
    cw      = bp ? 2 : (filt_ok ? 3 + d : 3 + T);
    ce      = cw + s;
    el      = filt_ok ? fl : l;
    er      = filt_ok ? fr : r;
    for (int c = 0; c <= ce; c++) begin
      @(negedge CLOCK_50);
      read_ready  = 1'b1;
      write_ready = !(c >= cw && c < cw + s);
      if (c <= 1) begin
        bypass         = bp;
        readdata_left  = l;
        readdata_right = r;
      end else begin
        bypass         = 1'($urandom);
        readdata_left  = 24'($urandom);
        readdata_right = 24'($urandom);
      end
      filt_done      = 1'b0;
      filt_out_left  = 24'($urandom);
      filt_out_right = 24'($urandom);
      if (!bp && early && c == 2) filt_done = 1'b1;
      if (filt_ok && c == 2 + d) begin
        filt_done      = 1'b1;
        filt_out_left  = fl;
        filt_out_right = fr;
      end
      if (!bp && !filt_ok && c == cw) m_to = 1'b1;
      #1;
      check("read", read, 32'(c == 1));
      check("filt_valid", filt_valid, 32'(!bp && c == 2));
      check("write", write, 32'(c == ce));
      check("busy", busy, 32'(c != 0));
      check("timeout_flag", timeout_flag, m_to);
      check("sample_count", sample_count, exp_count());
      if (c >= 2) begin
        check("filt_in_l", filt_in_left, l);
        check("filt_in_r", filt_in_right, r);
      end
      if (c == 0) begin
        check("wd_hold_l", writedata_left, m_wd_l);
        check("wd_hold_r", writedata_right, m_wd_r);
      end else if (c >= cw) begin
        check("wd_l", writedata_left, el);
        check("wd_r", writedata_right, er);
      end
    end
    m_wd_l = el;
    m_wd_r = er;
    m_cnt  = (m_cnt + 1) % 65536;
  endtask

  initial begin
    reset = 1'b1; read_ready = 1'b0; write_ready = 1'b0; bypass = 1'b0; filt_done = 1'b0;
    readdata_left = '0; readdata_right = '0; filt_out_left = '0; filt_out_right = '0;
    m_wd_l = '0; m_wd_r = '0; m_to = 1'b0; m_cnt = 0;
    repeat (2) @(negedge CLOCK_50);
    #1;
    check("rst_busy", busy, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_fv", filt_valid, 0);
    check("rst_wd_l", writedata_left, 0);
    check("rst_fi_l", filt_in_left, 0);
    check("rst_to", timeout_flag, 0);
    check("rst_cnt", sample_count, 0);
    reset = 1'b0;

    run_sample(1, 24'h123456, 24'habcdef, 0, 24'h0, 24'h0, 0, 0);
    run_sample(0, 24'h000100, 24'h000100, 3, 24'h000080, 24'h000080, 0, 0);
    run_sample(0, 24'h000100, 24'h000200, 3, 24'h000080, 24'h000100, 5, 0);
    run_sample(0, 24'h0a0b0c, 24'h0d0e0f, T, 24'h111111, 24'h222222, 0, 0);
    run_sample(0, 24'h0a0b0c, 24'h0d0e0f, 2, 24'h333333, 24'h444444, 1, 1);
    run_sample(0, 24'h5a5a5a, 24'ha5a5a5, 100, 24'h0, 24'h0, 2, 0);
    idle_cycles(3);

    for (int i = 0; i < 80; i++) begin
      idle_cycles(int'($urandom_range(0, 2)));
      run_sample(1'($urandom), 24'($urandom), 24'($urandom), int'($urandom_range(1, T + 3)),
                 24'($urandom), 24'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset while waiting on the filters; make sure the sticky flag is set first
    run_sample(0, 24'h777777, 24'h888888, 100, 24'h0, 24'h0, 0, 0);
    for (int c = 0; c <= 4; c++) begin
      @(negedge CLOCK_50);
      read_ready     = 1'b1;
      write_ready    = 1'b1;
      bypass         = 1'b0;
      filt_done      = 1'b0;
      readdata_left  = 24'h010203;
      readdata_right = 24'h040506;
      reset          = (c == 4);
      #1;
      if (c == 4) check("pre_rst_busy", busy, 1);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    read_ready = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read", read, 0);
    check("mid_rst_write", write, 0);
    check("mid_rst_fv", filt_valid, 0);
    check("mid_rst_to", timeout_flag, 0);
    check("mid_rst_wd_l", writedata_left, 0);
    check("mid_rst_wd_r", writedata_right, 0);
    check("mid_rst_fi_l", filt_in_left, 0);
    check("mid_rst_cnt", sample_count, 0);
    m_wd_l = '0; m_wd_r = '0; m_to = 1'b0; m_cnt = 0;
    idle_cycles(3);

    for (int i = 0; i < 10; i++) begin
      run_sample(1'($urandom), 24'($urandom), 24'($urandom), int'($urandom_range(1, T + 2)),
                 24'($urandom), 24'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
